// File: rtl/wb_pkg.sv
// Shared Wishbone cycle/burst encodings and the controller state type for wb_ram_burst.
package wb_pkg;

    typedef enum logic [2:0] {
        CTI_CLASSIC = 3'b000,
        CTI_INCR    = 3'b010,
        CTI_EOB     = 3'b111
    } cti_e;

    typedef enum logic [1:0] {
        BTE_LINEAR = 2'b00,
        BTE_WRAP4  = 2'b01,
        BTE_WRAP8  = 2'b10,
        BTE_WRAP16 = 2'b11
    } bte_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SINGLE,
        ST_BURST,
        ST_DONE
    } state_e;

    localparam int ROW_W      = 9;
    localparam int BANK_WORDS = 512;

endpackage

// File: rtl/ram512x32.sv
// Behavioural model of the 512x32 RAM macro: byte-lane write port, separate read port, 1-cycle read latency.
module ram512x32 (
    input  logic        clk,
    input  logic        we,
    input  logic [3:0]  sel,
    input  logic [8:0]  wadr,
    input  logic [31:0] wdat,
    input  logic [8:0]  radr,
    output logic [31:0] rdat
);

    logic [31:0] mem [512];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we && sel[i]) begin
                mem[wadr][8*i +: 8] <= wdat[8*i +: 8];
            end
        end
        rdat <= mem[radr];
    end

endmodule

// File: rtl/wb_burst_adr.sv
// Next-beat address for Wishbone bursts: linear increment or wrap-4/8/16 within an aligned block.
module wb_burst_adr
    import wb_pkg::*;
#(
    parameter int ADR_W = 11
) (
    input  logic [ADR_W:0] adr,
    input  logic [1:0]     bte,
    output logic [ADR_W:0] nxt
);

    always_comb begin
        nxt = adr + (ADR_W + 1)'(1);
        case (bte)
            BTE_WRAP4:  nxt = {adr[ADR_W:2], adr[1:0] + 2'd1};
            BTE_WRAP8:  nxt = {adr[ADR_W:3], adr[2:0] + 3'd1};
            BTE_WRAP16: nxt = {adr[ADR_W:4], adr[3:0] + 4'd1};
            default:    ;
        endcase
    end

endmodule

// File: rtl/wb_ram_burst.sv
// Wishbone B3 RAM slave built from banked 512x32 macros, with registered-feedback
// incrementing/wrapping bursts and out-of-range error reporting.
module wb_ram_burst
    import wb_pkg::*;
#(
    parameter int DEPTH    = 2048,
    parameter bit BURST_EN = 1'b1,
    localparam int ADR_W   = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [ADR_W:0]    wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [2:0]        wb_cti_i,
    input  logic [1:0]        wb_bte_i,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic [31:0]       wb_dat_o
);

    localparam int NR_BANKS        = DEPTH / BANK_WORDS;
    localparam int BANK_W          = (NR_BANKS > 1) ? $clog2(NR_BANKS) : 1;
    localparam logic [ADR_W:0] LIMIT = (ADR_W + 1)'(DEPTH);

    if (DEPTH < BANK_WORDS || (DEPTH % BANK_WORDS) != 0) begin : g_bad_depth
        $error("wb_ram_burst: DEPTH must be a positive multiple of 512");
    end

    function automatic logic oob(input logic [ADR_W:0] a);
        return a >= LIMIT;
    endfunction

    function automatic logic [BANK_W-1:0] bank_of(input logic [ADR_W:0] a);
        return BANK_W'(a >> ROW_W);
    endfunction

    state_e         state;
    logic [ADR_W:0] adr_q;
    logic [ADR_W:0] nxt_adr;
    logic [ADR_W:0] rd_adr;
    logic           we_q;
    logic           ack_q;
    logic           err_q;
    logic           req;
    logic           wr;
    logic [31:0]    bank_rdat [NR_BANKS];
    logic [31:0]    rdat_mux;

    wb_burst_adr #(.ADR_W(ADR_W)) u_burst_adr (
        .adr (adr_q),
        .bte (wb_bte_i),
        .nxt (nxt_adr)
    );

    assign req = wb_cyc_i & wb_stb_i;
    // Outside IDLE the macros prefetch the next beat so data is ready in the following ack cycle.
    assign rd_adr = (state == ST_IDLE) ? wb_adr_i : nxt_adr;
    // adr_q always holds the address of the beat currently being acknowledged.
    assign wr = ack_q & we_q & ~rst_i;

    for (genvar b = 0; b < NR_BANKS; b++) begin : g_bank
        ram512x32 u_ram (
            .clk  (clk_i),
            .we   (wr && (bank_of(adr_q) == BANK_W'(b))),
            .sel  (wb_sel_i),
            .wadr (adr_q[ROW_W-1:0]),
            .wdat (wb_dat_i),
            .radr (rd_adr[ROW_W-1:0]),
            .rdat (bank_rdat[b])
        );
    end

    always_comb begin
        rdat_mux = '0;
        for (int b = 0; b < NR_BANKS; b++) begin
            if (bank_of(adr_q) == BANK_W'(b)) rdat_mux = bank_rdat[b];
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_dat_o = ack_q ? rdat_mux : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            adr_q <= '0;
            we_q  <= 1'b0;
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        adr_q <= wb_adr_i;
                        we_q  <= wb_we_i;
                        ack_q <= ~oob(wb_adr_i);
                        err_q <= oob(wb_adr_i);
                        state <= (BURST_EN && wb_cti_i == CTI_INCR) ? ST_BURST : ST_SINGLE;
                    end
                end
                ST_SINGLE: state <= ST_DONE;
                ST_BURST: begin
                    if (!wb_cyc_i) begin
                        state <= ST_IDLE;
                    end else if (wb_stb_i) begin
                        adr_q <= nxt_adr;
                        ack_q <= ~oob(nxt_adr);
                        err_q <= oob(nxt_adr);
                        // Any cycle type other than incrementing marks this as the final beat.
                        if (wb_cti_i != CTI_INCR) state <= ST_SINGLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_ram_burst.sv
// Directed scoreboard bench for wb_ram_burst: drivers queue expected beats, a negedge monitor checks them.
module tb_wb_ram_burst;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [11:0] adr;
    logic [31:0] dat_i;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        err;
    logic [31:0] dat_o;

    typedef struct {
        int          cyc;
        bit          err;
        bit          chk;
        logic [31:0] dat;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          cyc_cnt = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    bit          started = 1'b0;
    bit          ok;
    logic [31:0] b_dat [8];
    logic [31:0] e_dat [8];
    bit          e_err [8];

    wb_ram_burst #(.DEPTH(2048), .BURST_EN(1'b1)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_we_i  (we),
        .wb_sel_i (sel),
        .wb_adr_i (adr),
        .wb_dat_i (dat_i),
        .wb_cti_i (cti),
        .wb_bte_i (bte),
        .wb_ack_o (ack),
        .wb_err_o (err),
        .wb_dat_o (dat_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input bit c, input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (c) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    always @(negedge clk) begin
        if (started) begin
            if (ack && err) check(1'b0, "ack_err_exclusive", {30'd0, ack, err}, 32'h0);
            if (ack || err) begin
                if (q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_beat: got ack=%0b err=%0b at cycle %0d, required no beat",
                             ack, err, cyc_cnt);
                end else begin
                    e  = q.pop_front();
                    ok = (cyc_cnt == e.cyc) && (err == e.err) && (!e.chk || dat_o == e.dat);
                    n_checks++;
                    if (ok) n_pass++;
                    else $display("FAIL beat: got cyc=%0d err=%0b dat=%h, required cyc=%0d err=%0b dat=%h",
                                  cyc_cnt, err, dat_o, e.cyc, e.err, e.dat);
                end
            end else begin
                check(dat_o == 32'h0, "idle_dat_zero", dat_o, 32'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = 12'h0; dat_i = 32'h0; cti = 3'b000; bte = 2'b00;
    endtask

    task automatic push(input bit x_err, input bit x_chk, input logic [31:0] x_dat);
        exp_t x;
        x.cyc = cyc_cnt + 1;
        x.err = x_err;
        x.chk = x_chk;
        x.dat = x_dat;
        q.push_back(x);
    endtask

    task automatic settle();
        repeat (4) tick();
        check(q.size() == 0, "drain", 32'(q.size()), 32'h0);
        q.delete();
    endtask

    task automatic classic(input bit w, input logic [11:0] a, input logic [31:0] d,
                           input logic [3:0] s, input bit x_err, input logic [31:0] x_dat);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s; cti = 3'b000; bte = 2'b00;
        push(x_err, !w || x_err, x_dat);
        tick();
        tick();
        bus_idle();
        settle();
    endtask

    task automatic setb(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3);
        b_dat[0] = d0; b_dat[1] = d1; b_dat[2] = d2; b_dat[3] = d3;
    endtask

    task automatic sete(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3);
        e_dat[0] = d0; e_dat[1] = d1; e_dat[2] = d2; e_dat[3] = d3;
        for (int i = 0; i < 8; i++) e_err[i] = 1'b0;
    endtask

    // Beat k is requested in cycle N+k and acknowledged in N+k+1, where its write data is driven.
    task automatic burst(input bit w, input logic [11:0] a, input logic [1:0] t,
                         input int n, input int gap_at, input int rst_at);
        int prev;
        prev = -1;
        cyc = 1'b1; we = w; adr = a; sel = 4'hF; bte = t;
        for (int k = 0; k < n; k++) begin
            if (k == gap_at) begin
                repeat (2) begin
                    stb = 1'b0;
                    dat_i = (prev >= 0) ? b_dat[prev] : 32'h0;
                    prev = -1;
                    tick();
                end
            end
            stb = 1'b1;
            cti = (k == n - 1) ? 3'b111 : 3'b010;
            dat_i = (prev >= 0) ? b_dat[prev] : 32'h0;
            if (k == rst_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                prev = -1;
                break;
            end
            push(e_err[k], !w || e_err[k], e_dat[k]);
            prev = k;
            tick();
        end
        if (prev >= 0) begin
            stb = 1'b1; cti = 3'b111; dat_i = b_dat[prev];
            tick();
        end
        bus_idle();
        settle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus_idle();
        repeat (3) tick();
        check(ack == 1'b0, "reset_ack", {31'd0, ack}, 32'h0);
        check(err == 1'b0, "reset_err", {31'd0, err}, 32'h0);
        check(dat_o == 32'h0, "reset_dat", dat_o, 32'h0);
        started = 1'b1;
        rst = 1'b0;
        tick();

        // Classic write then read back, plus a partial byte-lane write.
        classic(1'b1, 12'h005, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
        classic(1'b0, 12'h005, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF);
        classic(1'b1, 12'h005, 32'h11223344, 4'b0101, 1'b0, 32'h0);
        classic(1'b0, 12'h005, 32'h0, 4'hF, 1'b0, 32'hDE22BE44);

        // Linear write then read burst crossing bank 0 -> 1.
        setb(32'hA00001FE, 32'hA00001FF, 32'hA0000200, 32'hA0000201);
        sete(32'h0, 32'h0, 32'h0, 32'h0);
        burst(1'b1, 12'h1FE, 2'b00, 4, -1, -1);
        sete(32'hA00001FE, 32'hA00001FF, 32'hA0000200, 32'hA0000201);
        burst(1'b0, 12'h1FE, 2'b00, 4, -1, -1);

        // Wrap-4 write from 0x00E lands at E,F,C,D.
        setb(32'd1, 32'd2, 32'd3, 32'd4);
        sete(32'h0, 32'h0, 32'h0, 32'h0);
        burst(1'b1, 12'h00E, 2'b01, 4, -1, -1);
        sete(32'd1, 32'd2, 32'd3, 32'd4);
        burst(1'b0, 12'h00E, 2'b01, 4, -1, -1);
        classic(1'b0, 12'h00C, 32'h0, 4'hF, 1'b0, 32'd3);
        classic(1'b0, 12'h00D, 32'h0, 4'hF, 1'b0, 32'd4);

        // Out-of-range accesses err and leave row 0 of bank 0 untouched.
        classic(1'b1, 12'h000, 32'h12345678, 4'hF, 1'b0, 32'h0);
        classic(1'b0, 12'h800, 32'h0, 4'hF, 1'b1, 32'h0);
        classic(1'b1, 12'h800, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0);
        classic(1'b0, 12'h000, 32'h0, 4'hF, 1'b0, 32'h12345678);

        // Linear read running past the top of memory.
        classic(1'b1, 12'h7FF, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0);
        sete(32'hCAFEF00D, 32'h0, 32'h0, 32'h0);
        e_err[1] = 1'b1;
        e_err[2] = 1'b1;
        burst(1'b0, 12'h7FF, 2'b00, 3, -1, -1);

        // Reset asserted in the ack cycle of beat 2 of a write burst.
        setb(32'h55000100, 32'h55000101, 32'h55000102, 32'h55000103);
        sete(32'h0, 32'h0, 32'h0, 32'h0);
        burst(1'b1, 12'h100, 2'b00, 4, -1, -1);
        setb(32'hB0000100, 32'hB0000101, 32'hB0000102, 32'hB0000103);
        burst(1'b1, 12'h100, 2'b00, 4, -1, 3);
        sete(32'hB0000100, 32'hB0000101, 32'h55000102, 32'h55000103);
        burst(1'b0, 12'h100, 2'b00, 4, -1, -1);
        classic(1'b0, 12'h101, 32'h0, 4'hF, 1'b0, 32'hB0000101);

        // Read burst with a two-cycle strobe gap after beat 1.
        sete(32'hA00001FE, 32'hA00001FF, 32'hA0000200, 32'h0);
        burst(1'b0, 12'h1FE, 2'b00, 3, 2, -1);

        started = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
